signal_stats_capture: RTL and testbench
=======================================

Name: signal_stats_capture

Overview:
- Windowed statistics stage placed directly upstream of the in-system wire monitor.
- Observes a signed sample stream (e.g. modulator output or NCO phase increment) over fixed windows of 2^LOG2_WIN accepted samples.
- Publishes min, max and peak magnitude into held registers that stay stable between window ends, so an asynchronous JTAG probe reads coherent values.
- Outputs feed the monitor's data_in ports directly.

Parameters:
- WIDTH, 16, sample width; in_data is signed two's complement.
- LOG2_WIN, 10, window length = 2^LOG2_WIN accepted samples; legal range 1..20.
- CNT_WIDTH, 16, width of the published-window counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data is a sample this cycle; no backpressure, always accepted
- in_data  in  WIDTH  signed sample
- freeze  in  1  level; blocks publication while high
- clear  in  1  synchronous one-cycle clear
- min_out  out  WIDTH  signed minimum of last published window
- max_out  out  WIDTH  signed maximum of last published window
- peak_out  out  WIDTH  unsigned max |sample| of last published window
- mean_out  out  WIDTH  signed window mean (see Optional Feature)
- win_count  out  CNT_WIDTH  number of published windows, wraps modulo 2^CNT_WIDTH
- stats_valid  out  1  one-cycle pulse when held outputs update

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; sample counter 0; FSM to EMPTY; running registers 0.
- FSM has two states.
  - EMPTY: no sample yet in the current window.
  - ACCUM: window has at least one sample.
- Accepted sample in EMPTY: running min, max and peak load from that sample (no comparison against stale values); go to ACCUM; sample counter = 1.
- Accepted sample in ACCUM:
  - min = smaller of min and in_data (signed compare).
  - max = larger of max and in_data (signed compare).
  - peak = larger of peak and |in_data|.
  - Counter increments.
- |x| is computed at WIDTH bits unsigned. |-2^(WIDTH-1)| = 2^(WIDTH-1) is exact, with no saturation.
- Window end is the accepted sample that brings the count to 2^LOG2_WIN. When LOG2_WIN=1, the second sample is the last. At window end:
  - The final values (including that last sample) go to the held outputs on the same clock edge, visible the next cycle.
  - stats_valid pulses high for exactly that next cycle.
  - win_count increments on that edge.
  - FSM returns to EMPTY; counter = 0.
  - Latency from the last sample's in_valid edge to stats_valid/outputs: 1 cycle.
- freeze high at the window-end edge: accumulation and window sequencing continue, but held outputs, win_count and stats_valid do not update. That window is discarded.
- freeze has no effect on accumulation otherwise.
- in_valid low: no state change. Gaps are allowed anywhere in a window.
- clear high:
  - Has priority over in_valid and window end in the same cycle; the sample is discarded.
  - Next cycle: FSM EMPTY, counter 0, all held outputs 0, win_count 0, stats_valid 0.
- rst_n asserted mid-window: partial window is lost. The first window after release starts from the next accepted sample.
- Held outputs change only on publish, clear or reset.

Optional Feature:
- Macro: STATS_MEAN_EN.
- Defined:
  - A signed accumulator of WIDTH+LOG2_WIN bits loads on the first sample and adds each subsequent sample, so it never overflows.
  - On publish, mean_out = accumulator arithmetic-shifted right by LOG2_WIN (floor toward negative infinity), truncated to WIDTH. The result always fits.
  - Freeze and clear rules are the same as for min/max.
- Undefined: no accumulator is synthesised; mean_out is constant 0.

Test Plan:
- WIDTH=16, LOG2_WIN=2; samples 5,-3,100,-7 back-to-back -> one cycle after the 4th sample: min_out=-7, max_out=100, peak_out=100, stats_valid one pulse, win_count=1; with STATS_MEAN_EN mean_out=23 (95>>>2).
- Window -32768,0,1,2 with in_valid gaps of 3 cycles -> min_out=-32768, max_out=2, peak_out=32768; with STATS_MEAN_EN mean_out=-8192; outputs unchanged until the window end.
- Publish window 1,1,1,1, then window 9,9,9,9 with freeze held high -> outputs stay min=max=peak=1, win_count stays 1, no stats_valid; next unfrozen window 2,2,2,2 -> outputs 2, win_count=2.
- Two samples 50,60, then clear together with in_valid sample 70, then 1,2,3,4 -> outputs 0 right after clear; publish min=1, max=4, peak=4 (70 excluded, first window restarted).
- Assert rst_n low mid-window after samples 8,9 -> all outputs 0 immediately (asynchronous); after release, 3,3,3,3 -> publish 3/3/3, win_count=1.
- win_count wraparound with CNT_WIDTH=2: 5 windows -> win_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/signal_stats_capture.sv
// rtl/signal_stats_capture.sv - windowed min/max/peak stats with held outputs; mean gated by STATS_MEAN_EN
module signal_stats_capture #(
    parameter int WIDTH     = 16,
    parameter int LOG2_WIN  = 10,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 freeze,
    input  logic                 clear,
    output logic [WIDTH-1:0]     min_out,
    output logic [WIDTH-1:0]     max_out,
    output logic [WIDTH-1:0]     peak_out,
    output logic [WIDTH-1:0]     mean_out,
    output logic [CNT_WIDTH-1:0] win_count,
    output logic                 stats_valid
);

    typedef enum logic {EMPTY, ACCUM} state_t;

    state_t                   state, state_nxt;
    logic [LOG2_WIN-1:0]      cnt;
    logic signed [WIDTH-1:0]  run_min, run_max, smp;
    logic [WIDTH-1:0]         run_peak, in_abs;
    logic signed [WIDTH-1:0]  nxt_min, nxt_max;
    logic [WIDTH-1:0]         nxt_peak;
    logic                     accept, first, win_end, publish;

    assign smp    = $signed(in_data);
    // -2^(WIDTH-1) negates to itself, which read unsigned is the exact magnitude
    assign in_abs = in_data[WIDTH-1] ? ((~in_data) + WIDTH'(1)) : in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear)
            state_nxt = EMPTY;
        else if (accept) begin
            if (state == EMPTY)
                state_nxt = ACCUM;
            else if (win_end)
                state_nxt = EMPTY;
        end
    end

    always_comb begin
        accept  = in_valid && !clear;
        first   = accept && (state == EMPTY);
        win_end = accept && (state == ACCUM) && (cnt == {LOG2_WIN{1'b1}});
        publish = win_end && !freeze;
    end

    always_comb begin
        nxt_min  = first ? smp    : ((smp < run_min)     ? smp    : run_min);
        nxt_max  = first ? smp    : ((smp > run_max)     ? smp    : run_max);
        nxt_peak = first ? in_abs : ((in_abs > run_peak) ? in_abs : run_peak);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            run_min  <= '0;
            run_max  <= '0;
            run_peak <= '0;
        end else if (clear) begin
            cnt      <= '0;
            run_min  <= '0;
            run_max  <= '0;
            run_peak <= '0;
        end else if (accept) begin
            cnt      <= win_end ? '0 : cnt + LOG2_WIN'(1);
            run_min  <= nxt_min;
            run_max  <= nxt_max;
            run_peak <= nxt_peak;
        end
    end

    // Held outputs move only on publish so an asynchronous probe sees one coherent window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_out     <= '0;
            max_out     <= '0;
            peak_out    <= '0;
            win_count   <= '0;
            stats_valid <= 1'b0;
        end else if (clear) begin
            min_out     <= '0;
            max_out     <= '0;
            peak_out    <= '0;
            win_count   <= '0;
            stats_valid <= 1'b0;
        end else begin
            stats_valid <= publish;
            if (publish) begin
                min_out   <= nxt_min;
                max_out   <= nxt_max;
                peak_out  <= nxt_peak;
                win_count <= win_count + CNT_WIDTH'(1);
            end
        end
    end

`ifdef STATS_MEAN_EN
    localparam int ACC_W = WIDTH + LOG2_WIN;

    logic signed [ACC_W-1:0] acc, nxt_acc, smp_ext, mean_shift;

    assign smp_ext = {{LOG2_WIN{in_data[WIDTH-1]}}, in_data};

    always_comb begin
        nxt_acc    = first ? smp_ext : acc + smp_ext;
        mean_shift = nxt_acc >>> LOG2_WIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            mean_out <= '0;
        end else if (clear) begin
            acc      <= '0;
            mean_out <= '0;
        end else begin
            if (accept)
                acc <= nxt_acc;
            if (publish)
                mean_out <= mean_shift[WIDTH-1:0];
        end
    end
`else
    assign mean_out = '0;
`endif

endmodule

// File: tb/tb_signal_stats_capture.sv
// tb/tb_signal_stats_capture.sv - self-checking bench for signal_stats_capture against a window-queue model
module tb_signal_stats_capture;
    localparam int W = 16;
    localparam int L = 2;
    localparam int C = 2;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, freeze, clear;
    logic [W-1:0] in_data;
    logic [W-1:0] min_out, max_out, peak_out, mean_out;
    logic [C-1:0] win_count;
    logic         stats_valid;

    int checks = 0;
    int errors = 0;

    int           q[$];
    logic [W-1:0] e_min, e_max, e_peak, e_mean;
    logic [C-1:0] e_wc;
    logic         e_sv;
    logic [C-1:0] wrap_seq [5];

    always #5 clk = ~clk;

    signal_stats_capture #(.WIDTH(W), .LOG2_WIN(L), .CNT_WIDTH(C)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .freeze(freeze), .clear(clear), .min_out(min_out), .max_out(max_out),
        .peak_out(peak_out), .mean_out(mean_out), .win_count(win_count),
        .stats_valid(stats_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_min"},  {16'h0, min_out},  {16'h0, e_min});
        chk({tag, "_max"},  {16'h0, max_out},  {16'h0, e_max});
        chk({tag, "_peak"}, {16'h0, peak_out}, {16'h0, e_peak});
        chk({tag, "_mean"}, {16'h0, mean_out}, {16'h0, e_mean});
        chk({tag, "_wc"},   {30'h0, win_count}, {30'h0, e_wc});
        chk({tag, "_sv"},   {31'h0, stats_valid}, {31'h0, e_sv});
    endtask

    task automatic model_zero();
        q.delete();
        e_min = '0; e_max = '0; e_peak = '0; e_mean = '0; e_wc = '0; e_sv = 1'b0;
    endtask

    task automatic model_window();
        int mn, mx, pk, s, a, m;
        mn = q[0]; mx = q[0]; pk = 0; s = 0;
        foreach (q[i]) begin
            if (q[i] < mn) mn = q[i];
            if (q[i] > mx) mx = q[i];
            a = (q[i] < 0) ? -q[i] : q[i];
            if (a > pk) pk = a;
            s += q[i];
        end
`ifdef STATS_MEAN_EN
        m = (s >= 0) ? s / N : -((-s + N - 1) / N);
`else
        m = 0;
`endif
        e_min = mn[W-1:0]; e_max = mx[W-1:0]; e_peak = pk[W-1:0]; e_mean = m[W-1:0];
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic f, input logic c);
        in_valid = v; in_data = d; freeze = f; clear = c;
        @(posedge clk);
        if (c) begin
            model_zero();
        end else begin
            e_sv = 1'b0;
            if (v) begin
                q.push_back(int'($signed(d)));
                if (q.size() == N) begin
                    if (!f) begin
                        model_window();
                        e_wc++;
                        e_sv = 1'b1;
                    end
                    q.delete();
                end
            end
        end
        #1;
        check_all("step");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] rd;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; freeze = 1'b0; clear = 1'b0;
        model_zero();
        wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        idle(1);

        // Back-to-back window
        step(1'b1, 16'd5, 1'b0, 1'b0);
        step(1'b1, -16'sd3, 1'b0, 1'b0);
        step(1'b1, 16'd100, 1'b0, 1'b0);
        step(1'b1, -16'sd7, 1'b0, 1'b0);
        chk("t1_min", {16'h0, min_out}, 32'h0000_FFF9);
        chk("t1_max", {16'h0, max_out}, 32'd100);
        chk("t1_peak", {16'h0, peak_out}, 32'd100);
        chk("t1_wc", {30'h0, win_count}, 32'd1);
        chk("t1_sv", {31'h0, stats_valid}, 32'd1);
`ifdef STATS_MEAN_EN
        chk("t1_mean", {16'h0, mean_out}, 32'd23);
`endif
        idle(1);

        // Window with gaps, including the most negative sample
        step(1'b1, 16'h8000, 1'b0, 1'b0); idle(3);
        step(1'b1, 16'd0, 1'b0, 1'b0);    idle(3);
        step(1'b1, 16'd1, 1'b0, 1'b0);    idle(3);
        step(1'b1, 16'd2, 1'b0, 1'b0);
        chk("t2_min", {16'h0, min_out}, 32'h0000_8000);
        chk("t2_max", {16'h0, max_out}, 32'd2);
        chk("t2_peak", {16'h0, peak_out}, 32'h0000_8000);
`ifdef STATS_MEAN_EN
        chk("t2_mean", {16'h0, mean_out}, 32'h0000_E000);
`endif

        // Freeze discards a window
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 16'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 16'd9, 1'b1, 1'b0);
        chk("t3_frz_max", {16'h0, max_out}, 32'd1);
        chk("t3_frz_wc", {30'h0, win_count}, 32'd1);
        chk("t3_frz_sv", {31'h0, stats_valid}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 16'd2, 1'b0, 1'b0);
        chk("t3_max", {16'h0, max_out}, 32'd2);
        chk("t3_wc", {30'h0, win_count}, 32'd2);

        // Clear beats a coincident sample
        step(1'b1, 16'd50, 1'b0, 1'b0);
        step(1'b1, 16'd60, 1'b0, 1'b0);
        step(1'b1, 16'd70, 1'b0, 1'b1);
        chk("t4_clr_max", {16'h0, max_out}, 32'd0);
        for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0, 1'b0);
        chk("t4_min", {16'h0, min_out}, 32'd1);
        chk("t4_max", {16'h0, max_out}, 32'd4);
        chk("t4_peak", {16'h0, peak_out}, 32'd4);

        // Asynchronous reset mid-window
        step(1'b1, 16'd8, 1'b0, 1'b0);
        step(1'b1, 16'd9, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_min", {16'h0, min_out}, 32'd0);
        chk("t5_rst_wc", {30'h0, win_count}, 32'd0);
        model_zero();
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 16'd3, 1'b0, 1'b0);
        chk("t5_max", {16'h0, max_out}, 32'd3);
        chk("t5_peak", {16'h0, peak_out}, 32'd3);
        chk("t5_wc", {30'h0, win_count}, 32'd1);

        // win_count wraparound
        step(1'b0, '0, 1'b0, 1'b1);
        for (int w = 0; w < 5; w++) begin
            for (int i = 0; i < 4; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
            chk("t6_wrap", {30'h0, win_count}, {30'h0, wrap_seq[w]});
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0:       rd = 16'h8000;
                1:       rd = 16'h7FFF;
                default: rd = W'($urandom);
            endcase
            step(($urandom_range(0, 3) != 0), rd, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 63) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
